shift_arb: RTL and testbench

SHIFT_ARB -- requirements
Module: shift_arb

---
 rtl/shift_pkg.sv | 12 +
 rtl/shift_rr_arb.sv | 9 +
 rtl/shift_arb.sv | 73 +++++++
 tb/tb_shift_arb.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: opcode encoding, default width and result-register states shared by shift_arb.
package shift_pkg;
   typedef enum logic [1:0] {
      SHIFT_SLL  = 2'b00,
      SHIFT_SRL  = 2'b01,
      SHIFT_RSVD = 2'b10,
      SHIFT_SRA  = 2'b11
   } shift_op_e;
   localparam int SHIFT_WIDTH = 32;
   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;
endpackage

// File: rtl/shift_rr_arb.sv
// shift_rr_arb: two-way arbiter; on a tie the requester other than last_grant wins when enabled, else requester 0.
module shift_rr_arb (
   input  logic [1:0] valid,
   input  logic       last_grant,
   input  logic       enable,
   output logic [1:0] grant
);
   always_comb grant = (valid == 2'b11) ? ((enable & ~last_grant) ? 2'b10 : 2'b01) : valid;
endmodule

// File: rtl/shift_arb.sv
// shift_arb: two requesters share one shift datapath through a single-entry result register.
// Define SHIFT_ARB_RR_EN for round-robin tie breaking; default is fixed priority to requester 0.
module shift_arb
   import shift_pkg::*;
#(
   parameter int WIDTH = SHIFT_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [3:0]           req_op,
   input  logic [2*WIDTH-1:0]   req_a,
   input  logic [2*WIDTH-1:0]   req_b,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [WIDTH-1:0]     resp_data,
   output logic                 resp_id,
   output logic                 resp_err
);
`ifdef SHIFT_ARB_RR_EN
   localparam logic RR_EN = 1'b1;
`else
   localparam logic RR_EN = 1'b0;
`endif
   logic [0:0]              state;
   logic                    last_grant, can_accept, accept, sel, big;
   logic [1:0]              grant;
   shift_op_e               op;
   logic [WIDTH-1:0]        a, b, res;
   logic signed [WIDTH-1:0] sra;

   shift_rr_arb u_arb (
      .valid      (req_valid),
      .last_grant (last_grant),
      .enable     (RR_EN),
      .grant      (grant)
   );

   assign resp_valid = state == FULL;
   assign can_accept = (state == EMPTY) | (resp_valid & resp_ready);
   // Gate with reset_n so nothing looks acceptable while reset is held.
   assign req_ready  = grant & {2{can_accept & reset_n}};
   assign accept     = |(req_valid & req_ready);
   assign sel        = req_ready[1];
   assign a          = sel ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
   assign b          = sel ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
   assign op         = shift_op_e'(sel ? req_op[3:2] : req_op[1:0]);
   assign big        = b >= WIDTH'(WIDTH);
   assign sra        = $signed(a) >>> b;

   always_comb
      res = (op == SHIFT_SLL) ? (big ? '0 : a << b) :
            (op == SHIFT_SRL) ? (big ? '0 : a >> b) :
            (op == SHIFT_SRA) ? (big ? {WIDTH{a[WIDTH-1]}} : sra) : '0;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state      <= EMPTY;
         resp_data  <= '0;
         resp_id    <= 1'b0;
         resp_err   <= 1'b0;
         last_grant <= 1'b1;
      end else if (accept) begin
         state      <= FULL;
         resp_data  <= res;
         resp_id    <= sel;
         resp_err   <= op == SHIFT_RSVD;
         last_grant <= sel;
      end else if (resp_valid & resp_ready) begin
         state      <= EMPTY;
      end
endmodule

// File: tb/tb_shift_arb.sv
// tb_shift_arb: directed vectors with hand-computed results for shift_arb; honours SHIFT_ARB_RR_EN.
module tb_shift_arb;
`ifdef SHIFT_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   logic        clk = 1'b0, reset_n = 1'b0;
   logic [1:0]  req_valid = 2'b00, req_ready;
   logic [3:0]  req_op = 4'h0;
   logic [63:0] req_a = '0, req_b = '0;
   logic        resp_valid, resp_ready = 1'b1, resp_id, resp_err;
   logic [31:0] resp_data;
   int          n_cmp = 0, n_bad = 0;

   shift_arb #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called at a negedge; issues one request from requester r and checks the registered result.
   task automatic xfer(input string tag, input int r, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic exp_err);
      req_valid = r ? 2'b10 : 2'b01;
      req_op    = r ? {op, 2'b00} : {2'b00, op};
      req_a     = r ? {a, 32'h0} : {32'h0, a};
      req_b     = r ? {b, 32'h0} : {32'h0, b};
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      chk({tag, ".valid"}, {31'd0, resp_valid}, 32'd1);
      chk({tag, ".data"}, resp_data, exp);
      chk({tag, ".id"}, {31'd0, resp_id}, r);
      chk({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      req_valid = 2'b11;
      #1;
      chk("rst.valid", {31'd0, resp_valid}, 32'd0);
      chk("rst.data", resp_data, 32'd0);
      chk("rst.id", {31'd0, resp_id}, 32'd0);
      chk("rst.err", {31'd0, resp_err}, 32'd0);
      chk("rst.req_ready", {30'd0, req_ready}, 32'd0);
      req_valid = 2'b00;
      @(negedge clk);
      reset_n = 1'b1;
      // contention straight out of reset: requester 0 wins the first tie
      req_op = 4'h0;
      req_a  = {32'h0000_000B, 32'h0000_000A};
      req_b  = '0;
      req_valid = 2'b11;
      #1;
      chk("cont.first_ready", {30'd0, req_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("cont%0d.id", i), {31'd0, resp_id}, (RR && i % 2) ? 32'd1 : 32'd0);
         chk($sformatf("cont%0d.data", i), resp_data, (RR && i % 2) ? 32'hB : 32'hA);
      end
      req_valid = 2'b00;
      @(negedge clk);
      chk("cont.drained", {31'd0, resp_valid}, 32'd0);
      do_reset();
      xfer("single", 0, 2'b00, 32'h0000_0001, 32'd4, 32'h0000_0010, 1'b0);
      @(negedge clk);
      chk("single.drained", {31'd0, resp_valid}, 32'd0);
      // backpressure: hold a result, then drain and accept in one cycle
      req_valid = 2'b01; req_op = 4'b0000; req_a = {32'h0, 32'd3}; req_b = {32'h0, 32'd1};
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      req_valid = 2'b10; req_op = 4'b0100; req_a = {32'h0000_0100, 32'h0}; req_b = {32'd4, 32'h0};
      #1;
      chk("bp.ready_blocked", {30'd0, req_ready}, 32'd0);
      chk("bp.data0", resp_data, 32'd6);
      @(posedge clk);
      @(negedge clk);
      chk("bp.held_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp.held_data", resp_data, 32'd6);
      chk("bp.held_id", {31'd0, resp_id}, 32'd0);
      chk("bp.held_ready", {30'd0, req_ready}, 32'd0);
      resp_ready = 1'b1;
      #1;
      chk("bp.ready_on_drain", {30'd0, req_ready}, 32'd2);
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      chk("bp.next_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp.next_data", resp_data, 32'h10);
      chk("bp.next_id", {31'd0, resp_id}, 32'd1);
      // shift boundaries and reserved opcode
      xfer("sra_b40", 0, 2'b11, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 1'b0);
      xfer("srl_b40", 0, 2'b01, 32'h8000_0000, 32'd40, 32'h0000_0000, 1'b0);
      xfer("sra_b4", 1, 2'b11, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
      xfer("sll_b32", 1, 2'b00, 32'h0000_0001, 32'd32, 32'h0000_0000, 1'b0);
      xfer("sll_b31", 0, 2'b00, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0);
      xfer("sra_pos", 0, 2'b11, 32'h7000_0000, 32'd4, 32'h0700_0000, 1'b0);
      xfer("rsvd", 0, 2'b10, 32'h0000_FFFF, 32'd1, 32'h0000_0000, 1'b1);
      xfer("srl_after_rsvd", 0, 2'b01, 32'h0000_00F0, 32'd4, 32'h0000_000F, 1'b0);
      // reset while FULL discards the result asynchronously
      req_valid = 2'b01; req_op = 4'b0000; req_a = {32'h0, 32'd5}; req_b = '0;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      req_valid = 2'b11;
      chk("midrst.full", {31'd0, resp_valid}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst.valid", {31'd0, resp_valid}, 32'd0);
      chk("midrst.data", resp_data, 32'd0);
      chk("midrst.ready", {30'd0, req_ready}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      resp_ready = 1'b1;
      #1;
      chk("midrst.after_ready", {30'd0, req_ready}, 32'd1);
      req_valid = 2'b00;
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
